// File: rtl/bomb_detonator.sv
// bomb_detonator: captures a dropped bomb, counts its fuse down on game ticks,
// then grows a cross-shaped blast one cell per tick and reports player hits.
// Optional macro BOMB_QUEUE_EN adds a one-entry pending-bomb buffer.
module bomb_detonator #(
  parameter int unsigned COORD_W    = 6,
  parameter int unsigned FUSE_TICKS = 8,
  parameter int unsigned MAX_RADIUS = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tick,
  input  logic               bombEnable,
  input  logic [COORD_W-1:0] bombX,
  input  logic [COORD_W-1:0] bombY,
  input  logic [COORD_W-1:0] playerX,
  input  logic [COORD_W-1:0] playerY,
  output logic               bombAck,
  output logic               armed,
  output logic               blastActive,
  output logic [COORD_W-1:0] blastX,
  output logic [COORD_W-1:0] blastY,
  output logic [3:0]         blastRadius,
  output logic               playerHit,
  output logic               blastDone
);

  localparam int unsigned FUSE_W = 8;
  localparam int unsigned RAD_W  = 4;
  localparam int unsigned DIFF_W = COORD_W + 1;
  localparam int unsigned CMP_W  = (DIFF_W > RAD_W) ? DIFF_W : RAD_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BLAST = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [FUSE_W-1:0]  fuse_q, fuse_d;
  logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
  logic [RAD_W-1:0]   rad_q, rad_d;
  logic               ack_q, ack_d;
  logic               armed_q, armed_d;
  logic               active_q, active_d;
  logic               hit_q, hit_d;
  logic               done_q, done_d;

`ifdef BOMB_QUEUE_EN
  logic               pend_v_q, pend_v_d;
  logic [COORD_W-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic               q_take;
`endif

  logic [DIFF_W-1:0]  dx_raw, dy_raw, dx_abs, dy_abs;
  logic               on_col, on_row;

  // Absolute distances in one extra bit so edge bombs never alias across the map
  always_comb begin
    dx_raw = DIFF_W'(playerX) - DIFF_W'(bx_q);
    dy_raw = DIFF_W'(playerY) - DIFF_W'(by_q);
    dx_abs = dx_raw[DIFF_W-1] ? (DIFF_W'(0) - dx_raw) : dx_raw;
    dy_abs = dy_raw[DIFF_W-1] ? (DIFF_W'(0) - dy_raw) : dy_raw;
    on_col = (playerX == bx_q) && (CMP_W'(dy_abs) <= CMP_W'(rad_q));
    on_row = (playerY == by_q) && (CMP_W'(dx_abs) <= CMP_W'(rad_q));
    hit_d  = active_q && (on_col || on_row);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    fuse_d  = fuse_q;
    bx_d    = bx_q;
    by_d    = by_q;
    rad_d   = rad_q;
    ack_d   = 1'b0;
`ifdef BOMB_QUEUE_EN
    pend_v_d = pend_v_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    // The request visible during an ack cycle is the one just acknowledged
    q_take   = (state_q != ST_IDLE) && bombEnable && !pend_v_q && !ack_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bombEnable) begin
          bx_d    = bombX;
          by_d    = bombY;
          fuse_d  = FUSE_W'(FUSE_TICKS - 1);
          ack_d   = 1'b1;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (tick) begin
          if (fuse_q == '0) begin
            rad_d   = '0;
            state_d = ST_BLAST;
          end else begin
            fuse_d = fuse_q - FUSE_W'(1);
          end
        end
      end
      ST_BLAST: begin
        if (tick) begin
          if (rad_q == RAD_W'(MAX_RADIUS)) begin
            rad_d   = '0;
            state_d = ST_DONE;
          end else begin
            rad_d = rad_q + RAD_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef BOMB_QUEUE_EN
        if (pend_v_q) begin
          bx_d     = pend_x_q;
          by_d     = pend_y_q;
          fuse_d   = FUSE_W'(FUSE_TICKS - 1);
          pend_v_d = 1'b0;
          state_d  = ST_ARMED;
        end else if (q_take) begin
          bx_d    = bombX;
          by_d    = bombY;
          fuse_d  = FUSE_W'(FUSE_TICKS - 1);
          ack_d   = 1'b1;
          state_d = ST_ARMED;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef BOMB_QUEUE_EN
    // Park a request that arrives while busy
    if (q_take && (state_q != ST_DONE)) begin
      pend_v_d = 1'b1;
      pend_x_d = bombX;
      pend_y_d = bombY;
      ack_d    = 1'b1;
    end
`endif

    armed_d  = (state_d == ST_ARMED);
    active_d = (state_d == ST_BLAST);
    done_d   = (state_d == ST_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      fuse_q   <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      rad_q    <= '0;
      ack_q    <= 1'b0;
      armed_q  <= 1'b0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fuse_q   <= fuse_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      rad_q    <= rad_d;
      ack_q    <= ack_d;
      armed_q  <= armed_d;
      active_q <= active_d;
      hit_q    <= hit_d;
      done_q   <= done_d;
    end
  end

`ifdef BOMB_QUEUE_EN
  // Pending-bomb buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_v_q <= 1'b0;
      pend_x_q <= '0;
      pend_y_q <= '0;
    end else begin
      pend_v_q <= pend_v_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
    end
  end
`endif

  assign bombAck     = ack_q;
  assign armed       = armed_q;
  assign blastActive = active_q;
  assign blastX      = bx_q;
  assign blastY      = by_q;
  assign blastRadius = rad_q;
  assign playerHit   = hit_q;
  assign blastDone   = done_q;

endmodule

// File: tb/tb_bomb_detonator.sv
// Randomized self-checking bench for bomb_detonator against a tick-count model.
module tb_bomb_detonator;

  localparam int CW = 6;
  localparam int F  = 8;
  localparam int M  = 3;

  logic          clk = 1'b0;
  logic          resetn, tick, bombEnable;
  logic [CW-1:0] bombX, bombY, playerX, playerY;
  logic          bombAck, armed, blastActive, playerHit, blastDone;
  logic [CW-1:0] blastX, blastY;
  logic [3:0]    blastRadius;

  bomb_detonator #(.COORD_W(CW), .FUSE_TICKS(F), .MAX_RADIUS(M)) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .bombEnable(bombEnable),
    .bombX(bombX), .bombY(bombY), .playerX(playerX), .playerY(playerY),
    .bombAck(bombAck), .armed(armed), .blastActive(blastActive),
    .blastX(blastX), .blastY(blastY), .blastRadius(blastRadius),
    .playerHit(playerHit), .blastDone(blastDone)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: a bomb is described only by how many ticks have passed since capture
  bit m_busy, m_ack, m_hit, m_pend;
  int m_t, m_bx, m_by, m_qx, m_qy;

  function automatic bit m_armed();  return m_busy && m_t < F; endfunction
  function automatic bit m_active(); return m_busy && m_t >= F && m_t <= F + M; endfunction
  function automatic bit m_done();   return m_busy && m_t == F + M + 1; endfunction
  function automatic int m_radius(); return m_active() ? m_t - F : 0; endfunction

  function automatic int iabs(input int v); return (v < 0) ? -v : v; endfunction

  function automatic bit in_cross(input int px, input int py, input int cx, input int cy, input int r);
    return (px == cx && iabs(py - cy) <= r) || (py == cy && iabs(px - cx) <= r);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ack = 0; m_hit = 0; m_pend = 0;
    m_t = 0; m_bx = 0; m_by = 0; m_qx = 0; m_qy = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ack"},    32'(bombAck),     32'(m_ack));
    chk({tag, ".armed"},  32'(armed),       32'(m_armed()));
    chk({tag, ".active"}, 32'(blastActive), 32'(m_active()));
    chk({tag, ".bx"},     32'(blastX),      32'(m_bx));
    chk({tag, ".by"},     32'(blastY),      32'(m_by));
    chk({tag, ".rad"},    32'(blastRadius), 32'(m_radius()));
    chk({tag, ".hit"},    32'(playerHit),   32'(m_hit));
    chk({tag, ".done"},   32'(blastDone),   32'(m_done()));
  endtask

  // Advance the model on the pre-edge inputs, clock once, compare everything
  task automatic step(input string tag);
    bit nack, nhit, was_ack;
    nack    = 0;
    was_ack = m_ack;
    nhit    = m_active() && in_cross(int'(playerX), int'(playerY), m_bx, m_by, m_radius());
    if (!m_busy) begin
      if (bombEnable) begin
        m_busy = 1; m_t = 0; m_bx = int'(bombX); m_by = int'(bombY); nack = 1;
      end
    end else begin
`ifdef BOMB_QUEUE_EN
      if (bombEnable && !m_pend && !was_ack) begin
        m_pend = 1; m_qx = int'(bombX); m_qy = int'(bombY); nack = 1;
      end
`endif
      if (m_done()) begin
        m_busy = 0;
`ifdef BOMB_QUEUE_EN
        if (m_pend) begin
          m_busy = 1; m_t = 0; m_bx = m_qx; m_by = m_qy; m_pend = 0;
        end
`endif
      end else if (tick) begin
        m_t++;
      end
    end
    m_ack = nack;
    m_hit = nhit;
    @(posedge clk);
    #1;
    check_all(tag);
    if (m_ack) bombEnable = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic request(input int x, input int y);
    bombEnable = 1'b1;
    bombX = CW'(x);
    bombY = CW'(y);
  endtask

  // Run with a tick every `period` cycles until the model returns to idle
  task automatic run_out(input string tag, input int period);
    int cyc;
    cyc = 0;
    while (m_busy && cyc < 200) begin
      tick = (cyc % period == period - 1);
      step(tag);
      cyc++;
    end
    tick = 1'b0;
    chk({tag, ".finished"}, 32'(m_busy), 32'(0));
  endtask

  int hx[4] = '{10, 12, 11, 10};
  int hy[4] = '{22, 20, 21, 23};
  int he[4] = '{1, 1, 0, 0};

  initial begin
    int ticks, start_tick, k, cyc, dones;
    bit probe;
    tick = 0; bombEnable = 0; bombX = 0; bombY = 0; playerX = 0; playerY = 0;
    resetn = 1'b1;
    @(negedge clk);
    do_reset();

    // Capture and handshake
    request(10, 20);
    step("cap");
    chk("cap_ack", 32'(bombAck), 32'(1));
    chk("cap_x", 32'(blastX), 32'(10));
    chk("cap_y", 32'(blastY), 32'(20));
    chk("cap_armed", 32'(armed), 32'(1));
    step("cap2");
    chk("no_second_ack", 32'(bombAck), 32'(0));

    // Fuse, blast growth and hit pattern at radius 2
    ticks = 0; start_tick = -1; k = 0; cyc = 0; dones = 0;
    while (m_busy && cyc < 200) begin
      tick = (cyc % 4 == 3);
      probe = 0;
      if (m_active() && m_radius() == 2 && k < 4) begin
        playerX = CW'(hx[k]); playerY = CW'(hy[k]); probe = 1;
      end else begin
        playerX = 0; playerY = 0;
      end
      if (tick) ticks++;
      step("fuse");
      if (probe) begin
        chk($sformatf("hit_%0d_%0d", hx[k], hy[k]), 32'(playerHit), 32'(he[k]));
        k++;
      end
      if (blastActive && start_tick < 0) start_tick = ticks;
      if (blastDone) dones++;
      cyc++;
    end
    tick = 0;
    chk("blast_start_tick", 32'(start_tick), 32'(8));
    chk("done_pulses", 32'(dones), 32'(1));
    chk("probes", 32'(k), 32'(4));

    // Corner blast must not wrap to the far edge
    @(negedge clk);
    request(0, 0);
    playerX = CW'(63); playerY = 0;
    step("edge_cap");
    cyc = 0;
    while (m_busy && cyc < 100) begin
      tick = 1;
      step("edge");
      if (m_busy) chk("edge_nowrap", 32'(playerHit), 32'(0));
      cyc++;
    end
    tick = 0;

    // Reset in the middle of a blast abandons the bomb
    request(30, 30);
    playerX = 30; playerY = 31;
    step("rst_cap");
    cyc = 0;
    tick = 1;
    while (!(m_active() && m_radius() == 1) && cyc < 50) begin
      step("rst_run");
      cyc++;
    end
    tick = 0;
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_armed", 32'(armed), 32'(0));
    chk("rst_active", 32'(blastActive), 32'(0));
    chk("rst_rad", 32'(blastRadius), 32'(0));
    chk("rst_hit", 32'(playerHit), 32'(0));
    chk("rst_bx", 32'(blastX), 32'(0));
    chk("rst_done", 32'(blastDone), 32'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) step("post_rst");
    request(12, 13);
    step("new_cap");
    chk("new_ack", 32'(bombAck), 32'(1));

    // Second and third requests while armed
    for (int i = 0; i < 2; i++) step("q_wait");
    request(5, 5);
    step("q2");
`ifdef BOMB_QUEUE_EN
    chk("q2_ack", 32'(bombAck), 32'(1));
`else
    chk("q2_noack", 32'(bombAck), 32'(0));
    bombEnable = 0;
`endif
    request(7, 7);
    for (int i = 0; i < 3; i++) begin
      step("q3");
      chk("q3_noack", 32'(bombAck), 32'(0));
    end
    bombEnable = 0;
    cyc = 0;
    tick = 1;
    while (!m_done() && cyc < 100) begin
      step("q_run");
      cyc++;
    end
    tick = 0;
    step("q_after_done");
`ifdef BOMB_QUEUE_EN
    chk("q_rearmed", 32'(armed), 32'(1));
    chk("q_bx", 32'(blastX), 32'(5));
    chk("q_by", 32'(blastY), 32'(5));
`else
    chk("q_idle", 32'(armed), 32'(0));
`endif
    run_out("q_drain", 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      if (!bombEnable && $urandom_range(0, 9) == 0)
        request($urandom_range(0, 63), $urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) begin
        playerX = CW'(m_bx); playerY = CW'(m_by + $urandom_range(0, 8) - 4);
      end else if ($urandom_range(0, 1) == 0) begin
        playerY = CW'(m_by); playerX = CW'(m_bx + $urandom_range(0, 8) - 4);
      end else begin
        playerX = CW'($urandom_range(0, 63)); playerY = CW'($urandom_range(0, 63));
      end
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bomb_detonator.md
Name: bomb_detonator

Overview:
- Consumer side of the bomb drop interface: accepts a dropped bomb (bombEnable/bombX/bombY), runs a fuse countdown on game ticks, then produces a cross-shaped blast that grows one cell per tick.
- Reports when the player stands inside the blast, and acknowledges each bomb so the dropping block can clear its request.
- Sits between the bomb drop logic and the game-state/renderer logic, on the single game clock.

Parameters:
- COORD_W, 6, coordinate width of all X/Y ports.
- FUSE_TICKS, 8, number of tick pulses between capture and blast start (legal range 1..255).
- MAX_RADIUS, 3, final blast arm length in cells (legal range 0..15).

Ports:
- clk  in  1  game clock
- resetn  in  1  asynchronous active-low reset
- tick  in  1  one-cycle game-tick enable; all timing advances only on tick
- bombEnable  in  1  bomb request, level; held high until bombAck is seen
- bombX  in  COORD_W  bomb column, valid while bombEnable=1
- bombY  in  COORD_W  bomb row, valid while bombEnable=1
- playerX  in  COORD_W  current player column
- playerY  in  COORD_W  current player row
- bombAck  out  1  one-cycle pulse: request captured
- armed  out  1  fuse running
- blastActive  out  1  blast in progress
- blastX  out  COORD_W  latched blast centre column
- blastY  out  COORD_W  latched blast centre row
- blastRadius  out  4  current arm length
- playerHit  out  1  registered; player inside blast this cycle
- blastDone  out  1  one-cycle pulse when the blast ends

Behaviour:
- Reset (resetn=0, any time, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: bombAck, armed, blastActive, blastX, blastY, blastRadius, playerHit, blastDone.
  - Fuse counter goes to 0.
  - A reset in the middle of a fuse or blast abandons that bomb; no blastDone is produced.
- States: IDLE, ARMED, BLAST, DONE.
- IDLE:
  - If bombEnable=1, latch bombX/bombY into blastX/blastY.
  - Load fuse counter with FUSE_TICKS-1, pulse bombAck for 1 cycle, go to ARMED.
  - Capture is independent of tick.
- Request handshake:
  - Upstream must deassert bombEnable in the cycle after bombAck.
  - A bombEnable still high in that cycle is not re-captured, because the block is no longer in IDLE.
- ARMED (armed=1):
  - On tick with fuse=0, go to BLAST with blastRadius=0.
  - On tick with fuse>0, decrement fuse.
  - The blast therefore starts on the FUSE_TICKS-th tick after capture.
  - bombEnable is ignored in this state (see Optional Feature).
- BLAST (blastActive=1):
  - On tick with blastRadius=MAX_RADIUS, go to DONE.
  - On any other tick, increment blastRadius.
  - The blast lasts MAX_RADIUS+1 ticks.
- DONE:
  - Single cycle: blastDone=1, blastActive=0, blastRadius returns to 0.
  - Next state is IDLE.
- Hit detection:
  - playerHit is registered one cycle after the inputs.
  - The player is hit when blastActive=1 and either:
    - playerX=blastX and |playerY-blastY| <= blastRadius, or
    - playerY=blastY and |playerX-blastX| <= blastRadius.
- Distance arithmetic:
  - Differences are computed in COORD_W+1 bits, so there is no wrap-around.
  - A blast near coordinate 0 or 2^COORD_W-1 does not alias to the opposite edge.
- Simultaneous tick and capture in IDLE: the capture happens; that tick does not count toward the fuse.

Optional Feature:
- Macro: BOMB_QUEUE_EN.
- Defined: adds a one-entry pending buffer.
  - In ARMED, BLAST or DONE, when bombEnable=1 and the buffer is empty: store bombX/bombY and pulse bombAck.
  - On leaving DONE with the buffer full: go directly to ARMED with the buffered coordinates, a fresh fuse, and the buffer cleared. No IDLE cycle occurs.
  - When the buffer is already full, further requests get no ack.
  - Reset empties the buffer.
- Undefined:
  - No buffer exists.
  - Requests outside IDLE get no bombAck and stay pending upstream until the block returns to IDLE.

Test Plan:
- Reset then bombEnable=1, bombX=10, bombY=20 -> bombAck pulses next edge; blastX=10, blastY=20; armed=1; bombEnable dropped after ack causes no second ack.
- FUSE_TICKS=8, ticks every 4 cycles -> blastActive rises on the 8th tick after capture; blastRadius steps 0,1,2,3 on successive ticks; blastDone pulses 1 cycle after the 4th blast tick; return to IDLE.
- Blast at (10,20), radius 2: player at (10,22) -> playerHit=1; player (12,20) -> 1; player (11,21) -> 0; player (10,23) -> 0.
- Blast at (0,0), MAX_RADIUS=3, player (63,0) -> playerHit stays 0, with no edge wrap.
- Assert resetn=0 mid-BLAST at radius 1 -> all outputs 0 immediately; no blastDone; a new bomb is accepted after release.
- BOMB_QUEUE_EN: second bomb (5,5) requested while ARMED -> acked; a third request gets no ack; after blastDone the block goes straight to armed=1 with blastX=5, blastY=5.
